// File: rtl/div_core.sv
// ============================================================================
//  Module   : div_core
//  Purpose  : Iterative radix-2 restoring divider (DIV/DIVU) with start/done
//             handshake, cancel support and sign fix-up of quotient/remainder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sign_en,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_qd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_done;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_sa    = op1[WIDTH-1] & sign_en;
  assign w_sb    = op2[WIDTH-1] & sign_en;
  assign w_mag_a = w_sa ? -op1 : op1;
  assign w_mag_b = w_sb ? -op2 : op2;

  // Trial subtract runs over WIDTH+1 bits; the stored partial remainder is
  // always below the divisor, so WIDTH bits suffice between iterations.
  assign w_shift = {r_prem, r_qd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH];

  // On divide by zero r_qd carries the raw dividend instead of its magnitude.
  assign w_fix_q = r_zero ? {WIDTH{1'b1}} : (r_neg_q ? -r_qd : r_qd);
  assign w_fix_r = r_zero ? r_qd : (r_neg_r ? -r_prem : r_prem);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (op2 == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (cancel) begin
          w_next = S_IDLE;
        end else if (r_cnt == c_LAST) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_prem  <= '0;
      r_qd    <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_prem  <= '0;
            r_zero  <= (op2 == '0);
            r_qd    <= (op2 == '0) ? op1 : w_mag_a;
            r_dvs   <= w_mag_b;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
          end
        end
        S_CALC: begin
          if (!cancel) begin
            r_prem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_qd   <= {r_qd[WIDTH-2:0], w_qbit};
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!cancel) begin
            r_quot <= w_fix_q;
            r_rem  <= w_fix_r;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign quot = r_quot;
  assign rem  = r_rem;

endmodule

`default_nettype wire
